// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUctrl encodings and execute-stage FSM states.
// Also used by the ALU control decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for add/sub/logic/compare ops.
// Shift codes and undefined codes fall back to add; the wrapper handles shifts.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result_c
);

  always_comb begin
    o_result_c = i_a + i_b;
    case (i_op)
      ALU_SUB:  o_result_c = i_a - i_b;
      ALU_AND:  o_result_c = i_a & i_b;
      ALU_OR:   o_result_c = i_a | i_b;
      ALU_XOR:  o_result_c = i_a ^ i_b;
      ALU_SLT:  o_result_c = DATA_WIDTH'($signed(i_a) < $signed(i_b));
      ALU_SLTU: o_result_c = DATA_WIDTH'(i_a < i_b);
      default:  o_result_c = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: one-cycle arithmetic/logic/compare, one-bit-per-cycle
// serial shifter, valid/ready on both sides, registered result and Zero flag.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  Zero,
  output logic                  busy
);

  alu_state_t              r_state;
  alu_state_t              w_next_state;
  alu_state_t              w_accept_state;
  alu_op_t                 r_op;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0]   r_out;
  logic                    r_zero;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_is_shift;
  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic [DATA_WIDTH-1:0]   w_core_res;
  logic [DATA_WIDTH-1:0]   w_shifted;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_op       (ALUctrl),
    .i_a        (srcA),
    .i_b        (srcB),
    .o_result_c (w_core_res)
  );

  assign w_is_shift = is_shift_op(ALUctrl);
  assign w_shamt    = srcB[SHAMT_WIDTH-1:0];
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and in_ready; a drain and a new acceptance may share an edge.
  always_comb begin
    w_next_state   = r_state;
    w_in_ready     = 1'b0;
    w_accept_state = (w_is_shift && (w_shamt != '0)) ? ST_SHIFT : ST_DONE;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = !flush;
        if (in_valid && w_in_ready) w_next_state = w_accept_state;
      end
      ST_SHIFT: begin
        if (r_cnt == SHAMT_WIDTH'(1)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_in_ready = out_ready && !flush;
        if (out_ready) w_next_state = (in_valid && w_in_ready) ? w_accept_state : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  always_comb begin
    w_shifted = {r_acc[DATA_WIDTH-2:0], 1'b0};
    case (r_op)
      ALU_SRL: w_shifted = {1'b0, r_acc[DATA_WIDTH-1:1]};
      ALU_SRA: w_shifted = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
      default: w_shifted = {r_acc[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  // Result register only updates on completion, so partial shifts never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= ALU_ADD;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_op <= alu_op_t'(ALUctrl);
      if (w_is_shift) begin
        r_acc <= srcA;
        r_cnt <= w_shamt;
        if (w_shamt == '0) begin
          r_out  <= srcA;
          r_zero <= (srcA == '0);
        end
      end else begin
        r_out  <= w_core_res;
        r_zero <= (w_core_res == '0);
      end
    end else if ((r_state == ST_SHIFT) && !flush) begin
      r_acc <= w_shifted;
      r_cnt <= r_cnt - SHAMT_WIDTH'(1);
      if (r_cnt == SHAMT_WIDTH'(1)) begin
        r_out  <= w_shifted;
        r_zero <= (w_shifted == '0);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign ALUout    = r_out;
  assign Zero      = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus random
// ops checked against an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        Zero;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_res;

  multicycle_alu dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .srcA      (srcA),
    .srcB      (srcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .Zero      (Zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return 32'($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd5 || op == 4'd6 || op == 4'd7) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op from IDLE, measure latency, check result, optionally stall, drain.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input string tag);
    logic [31:0] exp_r;
    int exp_lat;
    int lat;
    bit ir_checked;
    exp_r      = ref_alu(op, a, b);
    exp_lat    = ref_latency(op, b);
    ir_checked = 0;
    in_valid = 1'b1; ALUctrl = op; srcA = a; srcB = b; out_ready = 1'b0;
    #1;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; srcA = $urandom; srcB = $urandom; ALUctrl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (!ir_checked) begin
        check({tag, " in_ready shifting"}, 32'(in_ready), 32'd0);
        ir_checked = 1;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, ALUout, exp_r);
    check({tag, " zero"}, 32'(Zero), 32'(exp_r == 32'd0));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall result"}, ALUout, exp_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drained"}, 32'(out_valid), 32'd0);
    last_res = exp_r;
  endtask

  task automatic reset_in_done(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    logic [31:0] exp_r;
    exp_r = ref_alu(op, a, b);
    in_valid = 1'b1; ALUctrl = op; srcA = a; srcB = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " pre valid"}, 32'(out_valid), 32'd1);
    check({tag, " pre result"}, ALUout, exp_r);
    check({tag, " pre zero"}, 32'(Zero), 32'(exp_r == 32'd0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, " rst valid"}, 32'(out_valid), 32'd0);
    check({tag, " rst result"}, ALUout, 32'd0);
    check({tag, " rst zero"}, 32'(Zero), 32'd0);
    check({tag, " rst busy"}, 32'(busy), 32'd0);
    last_res = 32'd0;
  endtask

  initial begin
    logic [31:0] exp_q [$];
    logic [31:0] e1;
    logic [31:0] e2;
    bit saw_valid;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUctrl = 4'd0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset ALUout", ALUout, 32'd0);
    check("reset Zero", 32'(Zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, "add ovf");
    do_op(4'd1, 32'd5, 32'd5, 0, "sub zero");
    do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0, "slt neg");
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0, "sltu big");
    do_op(4'd7, 32'h8000_0000, 32'h23, 0, "sra 3");
    do_op(4'd5, 32'd1, 32'd31, 0, "sll 31");
    do_op(4'd6, 32'hDEAD_BEEF, 32'h0, 0, "srl 0");
    do_op(4'd6, 32'h8000_0000, 32'hFFFF_FFE1, 0, "srl 1");
    do_op(4'hF, 32'd3, 32'd4, 0, "op 1111");
    do_op(4'hA, 32'hFFFF_FFFF, 32'd1, 0, "op 1010");

    // Back-to-back non-shift ops with out_ready held high.
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; ALUctrl = 4'($urandom_range(0, 4)); srcA = $urandom; srcB = $urandom;
        exp_q.push_back(ref_alu(ALUctrl, srcA, srcB));
      end else begin
        in_valid = 1'b0;
      end
      if (k > 0) begin
        e1 = exp_q.pop_front();
        check("b2b valid", 32'(out_valid), 32'd1);
        check("b2b result", ALUout, e1);
      end
      #1;
      if (k < 4) check("b2b in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("b2b drained", 32'(out_valid), 32'd0);

    // Hold out_ready low for 3 cycles while a new op waits, then drain+accept.
    e1 = ref_alu(4'd1, 32'd9, 32'd9);
    e2 = ref_alu(4'd0, 32'h1234, 32'h1111);
    in_valid = 1'b1; ALUctrl = 4'd1; srcA = 32'd9; srcB = 32'd9;
    @(posedge clk); #1;
    ALUctrl = 4'd0; srcA = 32'h1234; srcB = 32'h1111;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall valid", 32'(out_valid), 32'd1);
      check("stall result", ALUout, e1);
      check("stall zero", 32'(Zero), 32'd1);
      check("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("drain in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("drain+accept valid", 32'(out_valid), 32'd1);
    check("drain+accept result", ALUout, e2);
    check("drain+accept zero", 32'(Zero), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    last_res = e2;

    // Flush mid-shift: sll 1 by 20, flushed at cycle 5.
    in_valid = 1'b1; ALUctrl = 4'd5; srcA = 32'd1; srcB = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush stale result", ALUout, last_res);
    saw_valid = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1;
    end
    check("flush no late valid", 32'(saw_valid), 32'd0);
    do_op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, "post flush and");

    reset_in_done(4'd1, 32'd5, 32'd5, "rst sub");
    reset_in_done(4'hF, 32'd40, 32'd2, "rst add");

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 0) b = 32'($signed(b) >>> 28);
      do_op(op, a, b, int'($urandom_range(0, 2)), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Execute-stage ALU consuming the 4-bit `ALUctrl` code produced by the ALU control decoder, plus two register/immediate operands. Arithmetic, logic and compare ops complete in one cycle; shifts use a one-bit-per-cycle serial shifter to save area. A valid/ready handshake on both sides lets the pipeline control stall decode while a shift is in flight. The registered result and `Zero` flag feed writeback and branch resolution.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default `$clog2(DATA_WIDTH)`: shift-amount bits taken from `srcB`. Derived; not overridden.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `flush`  in  1: synchronous abort of the in-flight op, e.g. on branch redirect.
- `in_valid`  in  1: operands and `ALUctrl` are valid.
- `in_ready`  out  1: the block accepts an op this cycle.
- `ALUctrl`  in  4: op code. 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- `srcA`  in  DATA_WIDTH: operand A.
- `srcB`  in  DATA_WIDTH: operand B or immediate.
- `out_valid`  out  1: `ALUout` and `Zero` are valid.
- `out_ready`  in  1: the consumer takes the result.
- `ALUout`  out  DATA_WIDTH: registered result.
- `Zero`  out  1: registered flag, 1 when `ALUout == 0`.
- `busy`  out  1: state is not IDLE.

## Operation
- Acceptance occurs on a rising edge where `in_valid && in_ready`. Operands are captured at that edge; the inputs may change afterwards.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready` = 1.
  - On acceptance of a non-shift op, the result is computed combinationally and registered, and the FSM goes to DONE.
  - On acceptance of a shift, the accumulator is loaded with `srcA` and the count with `srcB[SHAMT_WIDTH-1:0]`. The FSM goes to SHIFT if the count is nonzero, or to DONE with result = `srcA` if it is zero.
- SHIFT:
  - `in_ready` = 0.
  - Each cycle the accumulator shifts by one bit and the count decrements.
  - sll fills with 0 from the LSB. srl fills with 0 from the MSB. sra replicates the MSB.
  - On the edge where the count reaches 0, the FSM goes to DONE.
- DONE:
  - `out_valid` = 1. `ALUout` and `Zero` are held stable until `out_ready`.
  - `in_ready` = `out_ready`, so a drain and a new acceptance can happen on the same edge. The FSM then follows the IDLE acceptance rules; with no new op it goes to IDLE.
- Arithmetic:
  - add and sub wrap modulo 2^DATA_WIDTH.
  - slt uses a signed compare and sltu an unsigned compare. Both give 1 or 0, zero-extended.
  - Upper bits of `srcB` are ignored for shifts.
  - Codes 1010–1111 are treated as add.
- `Zero` is registered together with `ALUout` and is recomputed from the final result.
- Reset (`rst`):
  - Clears the FSM to IDLE, with `out_valid` = 0, `ALUout` = 0, `Zero` = 0, and count and accumulator at 0.
  - Overrides `flush` and any acceptance.
- `flush`:
  - Forces IDLE on the next edge and discards the in-flight op or held result.
  - `in_ready` = 0 during the flush cycle, so no op is accepted.
  - `ALUout` and `Zero` keep their stale values with `out_valid` = 0.
  - `rst` or `flush` mid-shift aborts cleanly; a partial result is never presented.

## Timing
- Latency is measured from the acceptance edge to the first cycle with `out_valid` high:
  - Non-shift ops, and shifts by 0: 1 cycle.
  - Shifts by n: 1 + n cycles. Maximum DATA_WIDTH cycles, at n = DATA_WIDTH−1.
- Throughput: 1 op per cycle for back-to-back non-shift ops while `out_ready` is held high.
- No combinational path from `in_valid`, `srcA` or `srcB` to any output. `in_ready` depends combinationally only on state, `out_ready` and `flush`.
- Once `out_valid` rises, it stays high until `out_ready`, `flush` or `rst`.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum holding the 4-bit `ALUctrl` encodings above. The ALU control decoder uses the same package.
  - `alu_state_t` enum holding IDLE, SHIFT, DONE.
- Sub-module `alu_core`: purely combinational add, sub, and, or, xor, slt, sltu. `multicycle_alu` wraps it with the FSM, serial shifter and output register.

## Test plan
- add 0x7FFFFFFF + 1 → `ALUout` = 0x80000000, `Zero` = 0, `out_valid` one cycle after acceptance. sub 5 − 5 → 0, `Zero` = 1.
- slt −1 vs 1 → 1; sltu 0xFFFFFFFF vs 1 → 0.
- sra 0x80000000 by `srcB` = 0x23 (shamt 3) → 0xF0000000 after 4 cycles, with `in_ready` = 0 during SHIFT. sll 1 by 31 → 0x80000000 after 32 cycles. srl by 0 → `srcA` after 1 cycle.
- Back-to-back adds with `out_ready` tied high → one result per cycle, in order. With `out_ready` held low for 3 cycles → result and `Zero` stay stable and no new op is accepted.
- `flush` asserted mid-shift (sll 1 by 20, at cycle 5) → IDLE next cycle, `out_valid` never rises for that op, and the next op completes normally.
- `rst` during DONE with `out_ready` = 0 → `out_valid` = 0, `ALUout` = 0 and `Zero` = 0 on the next cycle. `ALUctrl` = 1111 → treated as add.
